// File: rtl/xor_chk_pkg.sv
// ============================================================================
// xor_chk_pkg: shared state encoding, default sizes and parity helper for the
// exhaustive XOR gate checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xor_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRIVE  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam int DEF_N_INPUTS      = 5;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_ERR_CNT_W     = 8;

  // Patterns are zero-extended to 16 bits, the widest legal gate.
  function automatic logic parity16(input logic [15:0] v);
    return ^v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xor_chk_settle_timer.sv
// ============================================================================
// xor_chk_settle_timer: loadable down-counter that pulses expire once a
// pattern has been held for SETTLE_CYCLES cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_chk_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expire = en && (count == 8'd0);

endmodule

`default_nettype wire

// File: rtl/xor_exhaustive_checker.sv
// ============================================================================
// xor_exhaustive_checker: sweeps every input pattern of an XOR gate and counts
// mismatches against reduction parity. Macro XOR_CHK_STOP_ON_FAIL_EN stops the
// sweep at the first mismatch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_exhaustive_checker
  import xor_chk_pkg::*;
#(
  parameter int N_INPUTS      = DEF_N_INPUTS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int ERR_CNT_W     = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_o,
  output logic [N_INPUTS-1:0]  pattern_o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_fail_valid,
  output logic [N_INPUTS-1:0]  first_fail_pattern
);

  localparam logic [N_INPUTS-1:0] ALL_ONES = '1;

  state_t               state;
  logic                 start_ok;
  logic                 expected;
  logic                 mismatch;
  logic                 last_pat;
  logic                 timer_clr;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_expire;
  logic [ERR_CNT_W-1:0] err_inc;

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign expected = parity16(16'(pattern_o));
  assign last_pat = (pattern_o == ALL_ONES);
  assign err_inc  = (err_count == '1) ? err_count : err_count + ERR_CNT_W'(1);

`ifdef SYNTHESIS
  assign mismatch = (dut_o != expected);
`else
  // Case inequality so an X/Z gate output is scored as a failure.
  assign mismatch = (dut_o !== expected);
`endif

  assign timer_en   = (state == ST_DRIVE);
  assign timer_load = start_ok || ((state == ST_SAMPLE) && !last_pat);
  assign timer_clr  = (state == ST_DONE) && !start;

  xor_chk_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      pattern_o          <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      err_count          <= '0;
      first_fail_valid   <= 1'b0;
      first_fail_pattern <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state              <= ST_DRIVE;
            pattern_o          <= '0;
            busy               <= 1'b1;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            first_fail_valid   <= 1'b0;
            first_fail_pattern <= '0;
          end
        end
        ST_DRIVE: begin
          if (timer_expire) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (!first_fail_valid) begin
              first_fail_valid   <= 1'b1;
              first_fail_pattern <= pattern_o;
            end
          end
`ifdef XOR_CHK_STOP_ON_FAIL_EN
          if (mismatch) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else
`endif
          if (last_pat) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == '0);
          end else begin
            state     <= ST_DRIVE;
            pattern_o <= pattern_o + N_INPUTS'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xor_exhaustive_checker.sv
// ============================================================================
// tb_xor_exhaustive_checker: scoreboard bench sweeping a modelled 5-input gate
// (ideal, stuck-at-0, XNOR, two-pattern fault) through the checker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_exhaustive_checker;

  localparam int N  = 5;
  localparam int S  = 2;
  localparam int EW = 4;

  typedef struct {
    int err;
    bit ffv;
    int ffp;
    bit pass;
    int pat;
    int done_edge;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          gate_out;
  logic [N-1:0]  pattern_o;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_count;
  logic          first_fail_valid;
  logic [N-1:0]  first_fail_pattern;

  int   mode;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  xor_exhaustive_checker #(
    .N_INPUTS      (N),
    .SETTLE_CYCLES (S),
    .ERR_CNT_W     (EW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .dut_o              (gate_out),
    .pattern_o          (pattern_o),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .err_count          (err_count),
    .first_fail_valid   (first_fail_valid),
    .first_fail_pattern (first_fail_pattern)
  );

  always #5 clk = ~clk;

  // Gate models: 0 ideal, 1 stuck-at-0, 2 XNOR, 3 flips patterns 7 and 20.
  function automatic logic gate_fn(input int m, input logic [N-1:0] p);
    case (m)
      0:       return ^p;
      1:       return 1'b0;
      2:       return ~(^p);
      default: return (^p) ^ ((p == 5'd7) || (p == 5'd20));
    endcase
  endfunction

  always_comb gate_out = gate_fn(mode, pattern_o);

  function automatic exp_t predict(input int m);
    exp_t         e;
    logic [N-1:0] pv;
    e.err = 0; e.ffv = 1'b0; e.ffp = 0; e.pat = (1 << N) - 1;
    e.done_edge = (1 << N) * (S + 1);
    for (int p = 0; p < (1 << N); p++) begin
      pv = N'(p);
      if (gate_fn(m, pv) != ^pv) begin
        if (e.err < (1 << EW) - 1) e.err++;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffp = p;
        end
`ifdef XOR_CHK_STOP_ON_FAIL_EN
        e.pat = p;
        e.done_edge = (p + 1) * (S + 1);
        break;
`endif
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic run_sweep(input int m, input bit hold);
    exp_t e;
    int   n;
    bit   busy_drop;
    mode = m;
    sb.push_back(predict(m));
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    vectors++;
    if ({busy, done, first_fail_valid, err_count, pattern_o} !== {1'b1, 1'b0, 1'b0, 4'h0, 5'h00}) begin
      miscompares++;
      $display("FAIL sweep_start mode=%0d busy=%b done=%b ffv=%b err=%h pat=%h required 1 0 0 0 00",
               m, busy, done, first_fail_valid, err_count, pattern_o);
    end
    n = 0;
    busy_drop = 1'b0;
    while (done !== 1'b1 && n < 2000) begin
      if (busy !== 1'b1) busy_drop = 1'b1;
      @(posedge clk);
      n++;
      #1;
    end
    e = sb.pop_front();
    vectors++;
    if (n != e.done_edge || busy_drop) begin
      miscompares++;
      $display("FAIL done_edge mode=%0d got edge %0d busy_drop=%b required edge %0d", m, n, busy_drop, e.done_edge);
    end
    vectors++;
    if (err_count !== EW'(e.err)) begin
      miscompares++;
      $display("FAIL err_count mode=%0d got %0d required %0d", m, err_count, e.err);
    end
    vectors++;
    if (first_fail_valid !== e.ffv || first_fail_pattern !== N'(e.ffp)) begin
      miscompares++;
      $display("FAIL first_fail mode=%0d got v=%b p=%h required v=%b p=%h",
               m, first_fail_valid, first_fail_pattern, e.ffv, e.ffp);
    end
    vectors++;
    if (pass !== e.pass || busy !== 1'b0 || pattern_o !== N'(e.pat)) begin
      miscompares++;
      $display("FAIL result mode=%0d got pass=%b busy=%b pat=%h required pass=%b busy=0 pat=%h",
               m, pass, busy, pattern_o, e.pass, e.pat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, pass, first_fail_valid, err_count, pattern_o, first_fail_pattern} !== '0) begin
      miscompares++;
      $display("FAIL reset busy=%b done=%b pass=%b ffv=%b err=%h pat=%h ffp=%h required all zero",
               busy, done, pass, first_fail_valid, err_count, pattern_o, first_fail_pattern);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweeps();
    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);
    run_sweep(3, 1'b0);
  endtask

  task automatic test_mid_reset();
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, pass, first_fail_valid, err_count, pattern_o, first_fail_pattern} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset busy=%b done=%b pass=%b ffv=%b err=%h pat=%h ffp=%h required all zero",
               busy, done, pass, first_fail_valid, err_count, pattern_o, first_fail_pattern);
    end
    #2;
    rst_n = 1'b1;
    run_sweep(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep(1, 1'b1);
    run_sweep(0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mode        = 0;
    test_reset();
    test_sweeps();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
